// File: rtl/hex_display_scanner.sv
// hex_display_scanner
// Time-multiplexed driver for a bank of common-anode 7-segment digits.
// Holds a double-buffered copy of the display registers and scans one digit
// per slot. Each slot is SCAN_DIV lit cycles followed by GUARD_CYCLES
// all-dark cycles. Supports per-digit blanking, blinking and decimal points,
// and raises a one-cycle frame_done strobe at the start of every frame after
// the first.
// Optional build macro: HEX_LEADING_ZERO_BLANK_EN adds an lz_en input that
// suppresses leading zero digits.
`timescale 1ns/1ps

module hex_display_scanner #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD_CYCLES = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
`ifdef HEX_LEADING_ZERO_BLANK_EN
    input  logic                    lz_en,
`endif
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int CNT_MAX = (SCAN_DIV > GUARD_CYCLES) ? SCAN_DIV : GUARD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRM_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [NUM_DIGITS-1:0] DIGIT_ONE = NUM_DIGITS'(1);

    typedef enum logic [0:0] {
        ST_SHOW  = 1'b0,
        ST_GUARD = 1'b1
    } scan_state_t;

    // Active-low 7-segment pattern (bit0 = a .. bit6 = g) for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            4'hF:    pat = 7'b0001110;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    // Shadow copy of the display registers
    logic [4*NUM_DIGITS-1:0] data_r;
    logic [NUM_DIGITS-1:0]   dp_sh_r;
    logic [NUM_DIGITS-1:0]   blank_r;
    logic [NUM_DIGITS-1:0]   blink_r;
    logic                    lz_en_r;

    // Scan state
    scan_state_t      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [IDX_W-1:0] idx_r;
    logic [FRM_W-1:0] frame_cnt_r;
    logic             blink_phase_r;
    logic             wrap_r;

    // Registered outputs
    logic [6:0]            seg_r;
    logic                  dp_r;
    logic [NUM_DIGITS-1:0] digit_en_r;
    logic                  frame_done_r;

    // Next-state and per-slot display values
    scan_state_t      state_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [IDX_W-1:0] idx_nxt_s;
    logic             advance_s;
    logic             wrap_s;
    logic [NUM_DIGITS-1:0] lz_dark_s;
    logic             zero_run_s;
    logic [3:0]       cur_nib_s;
    logic             dark_s;
    logic [6:0]       show_seg_s;
    logic             show_dp_s;

    // Capture all *_in buses into the shadow registers while load is high.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            data_r  <= '0;
            dp_sh_r <= '0;
            blank_r <= '0;
            blink_r <= '0;
            lz_en_r <= 1'b0;
        end else if (load) begin
            data_r  <= data_in;
            dp_sh_r <= dp_in;
            blank_r <= blank_in;
            blink_r <= blink_in;
`ifdef HEX_LEADING_ZERO_BLANK_EN
            lz_en_r <= lz_en;
`else
            lz_en_r <= 1'b0;
`endif
        end else begin
            data_r  <= data_r;
            dp_sh_r <= dp_sh_r;
            blank_r <= blank_r;
            blink_r <= blink_r;
            lz_en_r <= lz_en_r;
        end
    end

    // Leading-zero suppression mask: a zero run counted down from the top digit.
    always_comb begin
        lz_dark_s  = '0;
        zero_run_s = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run_s   = zero_run_s & (data_r[4*i +: 4] == 4'h0);
            lz_dark_s[i] = lz_en_r & zero_run_s & ~dp_sh_r[i] & (i != 0);
        end
    end

    // Segment and dp pattern for the digit currently owning the slot.
    always_comb begin
        cur_nib_s  = data_r[{idx_r, 2'b00} +: 4];
        dark_s     = blank_r[idx_r] | (blink_r[idx_r] & blink_phase_r) | lz_dark_s[idx_r];
        if (dark_s) begin
            show_seg_s = 7'b1111111;
            show_dp_s  = 1'b1;
        end else begin
            show_seg_s = hex_to_seg(cur_nib_s);
            show_dp_s  = ~dp_sh_r[idx_r];
        end
    end

    // Slot sequencing: SHOW for SCAN_DIV cycles, then GUARD, then next digit.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r + CNT_W'(1);
        idx_nxt_s   = idx_r;
        advance_s   = 1'b0;
        wrap_s      = 1'b0;
        case (state_r)
            ST_SHOW: begin
                if (cnt_r == SCAN_LAST) begin
                    if (GUARD_CYCLES > 0) begin
                        state_nxt_s = ST_GUARD;
                        cnt_nxt_s   = '0;
                    end else begin
                        advance_s = 1'b1;
                    end
                end else begin
                    advance_s = 1'b0;
                end
            end
            ST_GUARD: begin
                if (cnt_r == GUARD_LAST) begin
                    advance_s = 1'b1;
                end else begin
                    advance_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_SHOW;
                cnt_nxt_s   = '0;
            end
        endcase
        if (advance_s) begin
            state_nxt_s = ST_SHOW;
            cnt_nxt_s   = '0;
            if (idx_r == IDX_LAST) begin
                idx_nxt_s = '0;
                wrap_s    = 1'b1;
            end else begin
                idx_nxt_s = idx_r + IDX_W'(1);
            end
        end else begin
            wrap_s = 1'b0;
        end
    end

    // Scan FSM with blink timing and registered pin outputs; the outputs
    // present the slot position held before each edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r       <= ST_SHOW;
            cnt_r         <= '0;
            idx_r         <= '0;
            frame_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
            wrap_r        <= 1'b0;
            seg_r         <= 7'b1111111;
            dp_r          <= 1'b1;
            digit_en_r    <= '1;
            frame_done_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            idx_r        <= idx_nxt_s;
            wrap_r       <= wrap_s;
            frame_done_r <= wrap_r;
            // The blink phase flips on the wrap edge so the whole new frame uses it.
            if (wrap_s) begin
                if (frame_cnt_r == FRM_LAST) begin
                    frame_cnt_r   <= '0;
                    blink_phase_r <= ~blink_phase_r;
                end else begin
                    frame_cnt_r   <= frame_cnt_r + FRM_W'(1);
                end
            end
            if (state_r == ST_SHOW) begin
                seg_r      <= show_seg_s;
                dp_r       <= show_dp_s;
                digit_en_r <= ~(DIGIT_ONE << idx_r);
            end else begin
                seg_r      <= 7'b1111111;
                dp_r       <= 1'b1;
                digit_en_r <= '1;
            end
        end
    end

    assign seg        = seg_r;
    assign dp         = dp_r;
    assign digit_en   = digit_en_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench for hex_display_scanner with NUM_DIGITS=4, SCAN_DIV=4,
// GUARD_CYCLES=1, BLINK_FRAMES=2. A frame-arithmetic model predicts every
// output on every cycle; directed literal checks pin the model.
`timescale 1ns/1ps

module tb_hex_display_scanner;

    localparam int ND    = 4;
    localparam int SCAN  = 4;
    localparam int GUARD = 1;
    localparam int BLINK = 2;
    localparam int SLOT  = SCAN + GUARD;
    localparam int FRAME = ND * SLOT;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic          clock;
    logic          resetn;
    logic          load;
    logic [15:0]   data_in;
    logic [3:0]    dp_in;
    logic [3:0]    blank_in;
    logic [3:0]    blink_in;
`ifdef HEX_LEADING_ZERO_BLANK_EN
    logic          lz_en;
`endif
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    digit_en;
    logic          frame_done;

    int cmp_cnt = 0;
    int err_cnt = 0;

    hex_display_scanner #(
        .NUM_DIGITS  (ND),
        .SCAN_DIV    (SCAN),
        .GUARD_CYCLES(GUARD),
        .BLINK_FRAMES(BLINK)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .load      (load),
        .data_in   (data_in),
        .dp_in     (dp_in),
        .blank_in  (blank_in),
        .blink_in  (blink_in),
`ifdef HEX_LEADING_ZERO_BLANK_EN
        .lz_en     (lz_en),
`endif
        .seg       (seg),
        .dp        (dp),
        .digit_en  (digit_en),
        .frame_done(frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          k = 0;          // edges since reset release
    logic [15:0] m_data;
    logic [3:0]  m_dp, m_blank, m_blink;
    logic        m_lz;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_en;
    logic        e_fd;

    always begin
        int   p, f, s, w;
        logic phase, dark;
        logic [3:0] nib;
        @(posedge clock);
        if (!resetn) begin
            k = 0;
            m_data = 16'h0; m_dp = 4'h0; m_blank = 4'h0; m_blink = 4'h0; m_lz = 1'b0;
            e_seg = 7'h7F; e_dp = 1'b1; e_en = 4'hF; e_fd = 1'b0;
        end else begin
            k++;
            p = k - 1;
            f = p / FRAME;
            s = (p % FRAME) / SLOT;
            w = p % SLOT;
            e_fd = (p > 0) && (p % FRAME == 0);
            if (w < SCAN) begin
                nib   = 4'((m_data >> (4 * s)) & 16'hF);
                phase = ((f / BLINK) % 2) == 1;
                dark  = m_blank[s] | (m_blink[s] & phase);
`ifdef HEX_LEADING_ZERO_BLANK_EN
                if (m_lz && s != 0 && !m_dp[s] && (m_data >> (4 * s)) == 16'h0) dark = 1'b1;
`endif
                e_en  = ~(4'b0001 << s);
                e_seg = dark ? 7'h7F : SEG_TAB[nib];
                e_dp  = dark ? 1'b1 : ~m_dp[s];
            end else begin
                e_en = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end
            if (load) begin
                m_data = data_in; m_dp = dp_in; m_blank = blank_in; m_blink = blink_in;
`ifdef HEX_LEADING_ZERO_BLANK_EN
                m_lz = lz_en;
`endif
            end
        end
        #1;
        check("mdl_seg", {25'd0, seg}, {25'd0, e_seg});
        check("mdl_dp", {31'd0, dp}, {31'd0, e_dp});
        check("mdl_en", {28'd0, digit_en}, {28'd0, e_en});
        check("mdl_fd", {31'd0, frame_done}, {31'd0, e_fd});
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_fd(input int bound);
        bit found = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clock); #2;
            if (frame_done) begin
                found = 1'b1;
                break;
            end
        end
        check("fd_wait", {31'd0, found}, 32'd1);
    endtask

    task automatic at_edge(input int target);
        int n = 0;
        while (k < target && n < 1000) begin
            @(posedge clock); #2;
            n++;
        end
        check("edge_reach", k, target);
    endtask

    task automatic step_slot(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic check_release(input string tag);
        for (int i = 0; i < SCAN; i++) begin
            @(posedge clock); #2;
            check({tag, "_show_en"}, {28'd0, digit_en}, 32'h0000000E);
        end
        @(posedge clock); #2;
        check({tag, "_guard_en"}, {28'd0, digit_en}, 32'h0000000F);
    endtask

    initial begin
        int fd_n;
        resetn = 1'b0; load = 1'b0; data_in = 16'h0;
        dp_in = 4'h0; blank_in = 4'h0; blink_in = 4'h0;
`ifdef HEX_LEADING_ZERO_BLANK_EN
        lz_en = 1'b0;
`endif
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        check_release("rel1");

        // Asynchronous reset in the middle of digit 1's slot.
        repeat (2) @(negedge clock);
        resetn = 1'b0;
        #1;
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_dp", {31'd0, dp}, 32'd1);
        check("rst_en", {28'd0, digit_en}, 32'hF);
        check("rst_fd", {31'd0, frame_done}, 32'd0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        check_release("rel2");

        // Load 3A7F and walk one frame of slots.
        @(negedge clock);
        data_in = 16'h3A7F; load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        wait_fd(40);
        check("ld_d0_seg", {25'd0, seg}, {25'd0, 7'b0001110});
        check("ld_d0_en", {28'd0, digit_en}, 32'hE);
        step_slot(SLOT);
        check("ld_d1_seg", {25'd0, seg}, {25'd0, 7'b1111000});
        check("ld_d1_en", {28'd0, digit_en}, 32'hD);
        step_slot(SLOT);
        check("ld_d2_seg", {25'd0, seg}, {25'd0, 7'b0001000});
        check("ld_d2_en", {28'd0, digit_en}, 32'hB);
        step_slot(SLOT);
        check("ld_d3_seg", {25'd0, seg}, {25'd0, 7'b0110000});
        check("ld_d3_en", {28'd0, digit_en}, 32'h7);

        // frame_done count over five frames with a mid-frame load.
        wait_fd(40);
        fd_n = 0;
        for (int i = 0; i < 5 * FRAME; i++) begin
            @(posedge clock); #2;
            if (frame_done) fd_n++;
            if (i == 46) begin
                data_in = 16'hC0DE; load = 1'b1;
            end else begin
                load = 1'b0;
            end
        end
        check("fd_count", fd_n, 32'd5);

        // Blink / blank / dp from a fresh reset.
        @(negedge clock);
        resetn = 1'b0;
        data_in = 16'h1234; blank_in = 4'b1000; blink_in = 4'b0010; dp_in = 4'b1100;
        @(negedge clock);
        resetn = 1'b1; load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        for (int f = 0; f < 6; f++) begin
            at_edge(FRAME * f + 7);
            check("blk_d1_seg", {25'd0, seg}, (f == 2 || f == 3) ? 32'h7F : {25'd0, 7'b0110000});
            at_edge(FRAME * f + 12);
            check("dp_d2_seg", {25'd0, seg}, {25'd0, 7'b0100100});
            check("dp_d2_dp", {31'd0, dp}, 32'd0);
            at_edge(FRAME * f + 15);
            check("dp_guard", {31'd0, dp}, 32'd1);
            at_edge(FRAME * f + 17);
            check("blank_d3_en", {28'd0, digit_en}, 32'h7);
            check("blank_d3_seg", {25'd0, seg}, 32'h7F);
            check("blank_d3_dp", {31'd0, dp}, 32'd1);
        end

`ifdef HEX_LEADING_ZERO_BLANK_EN
        // Leading-zero suppression of 0050.
        @(negedge clock);
        data_in = 16'h0050; blank_in = 4'h0; blink_in = 4'h0; dp_in = 4'h0; lz_en = 1'b1; load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        wait_fd(40);
        check("lz_d0_seg", {25'd0, seg}, {25'd0, 7'b1000000});
        step_slot(SLOT);
        check("lz_d1_seg", {25'd0, seg}, {25'd0, 7'b0010010});
        step_slot(SLOT);
        check("lz_d2_seg", {25'd0, seg}, 32'h7F);
        step_slot(SLOT);
        check("lz_d3_seg", {25'd0, seg}, 32'h7F);
        @(negedge clock);
        dp_in = 4'b1000; load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        wait_fd(40);
        step_slot(2 * SLOT);
        check("lzdp_d2_seg", {25'd0, seg}, 32'h7F);
        step_slot(SLOT);
        check("lzdp_d3_seg", {25'd0, seg}, {25'd0, 7'b1000000});
        check("lzdp_d3_dp", {31'd0, dp}, 32'd0);
`endif

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
